// File: rtl/int_bit_manip_unit.sv
// -----------------------------------------------------------------------------
// int_bit_manip_unit
//   Registered integer bit-manipulation unit. Operand A is modified using the
//   low IDXW bits of operand B as a bit index or shift/rotate amount. The
//   result is computed combinationally and captured every clock edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (out <= 0)
//   operation  3-bit op select:
//                000 clear bit   001 set bit     010 get bit   011 load
//                100 shl logical 101 shr logical 110 shr arith 111 rotate left
//   opa        data word
//   opb        index/amount source; only opb[IDXW-1:0] is used
//   out        registered result, 1-cycle latency
// -----------------------------------------------------------------------------
module int_bit_manip_unit #(
  parameter int WIDTH = 64,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [IDXW-1:0]         idx;
  logic [WIDTH-1:0]        bit_mask;
  logic signed [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0]        sra_res;
  logic [2*WIDTH-1:0]      rot_wide;
  logic [WIDTH-1:0]        out_nxt;

  assign idx      = opb[IDXW-1:0];
  assign bit_mask = ONE << idx;
  assign opa_s    = opa;
  assign sra_res  = opa_s >>> idx;

  // Rotating a doubled word and keeping its upper half gives the rotate
  // without ever shifting by WIDTH, so idx=0 returns opa exactly.
  assign rot_wide = {opa, opa} << idx;

  always_comb begin
    out_nxt = opa;
    case (operation)
      3'b000:  out_nxt = opa & ~bit_mask;
      3'b001:  out_nxt = opa | bit_mask;
      3'b010:  out_nxt = {{(WIDTH-1){1'b0}}, opa[idx]};
      3'b011:  out_nxt = opa;
      3'b100:  out_nxt = opa << idx;
      3'b101:  out_nxt = opa >> idx;
      3'b110:  out_nxt = sra_res;
      3'b111:  out_nxt = rot_wide[2*WIDTH-1:WIDTH];
      default: out_nxt = opa;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= out_nxt;
  end

endmodule

// File: tb/tb_int_bit_manip_unit.sv
// -----------------------------------------------------------------------------
// tb_int_bit_manip_unit
//   Directed-vector bench. Each applied vector pushes its hand-computed
//   expected result into a scoreboard queue; an independent monitor pops one
//   entry shortly after every rising edge and compares it with out.
// -----------------------------------------------------------------------------
module tb_int_bit_manip_unit;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       operation;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] out;

  typedef struct {
    logic [WIDTH-1:0] exp;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  int_bit_manip_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .opa       (opa),
    .opb       (opb),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the result appears after the next rise.
  task automatic apply(input logic r, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    rst       = r;
    operation = op;
    opa       = a;
    opb       = b;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per edge once stimulus has started.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (out !== e.exp) begin
        failures++;
        $display("FAIL %s: out=%h expected=%h", e.name, out, e.exp);
      end
    end
  end

  initial begin
    rst = 1'b1; operation = 3'b011; opa = '0; opb = '0;

    // reset and release
    apply(1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h0, "reset_c1");
    apply(1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h0, "reset_c2");
    apply(0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "load_after_reset");
    apply(0, 3'b011, 64'hDEAD_BEEF_0123_4567, 64'h5, 64'hDEAD_BEEF_0123_4567, "load_pattern");

    // clear / set
    apply(0, 3'b000, 64'h0000_0000_0000_00FF, 64'd3,    64'h0000_0000_0000_00F7, "clr_bit3");
    apply(0, 3'b001, 64'h0000_0000_0000_00FF, 64'd63,   64'h8000_0000_0000_00FF, "set_bit63");
    apply(0, 3'b000, 64'h0000_0000_0000_00FF, 64'h43,   64'h0000_0000_0000_00F7, "clr_upper_opb_ignored");
    apply(0, 3'b001, 64'h0000_0000_0000_00FF, 64'd0,    64'h0000_0000_0000_00FF, "set_already_set");
    apply(0, 3'b000, 64'h0000_0000_0000_00FF, 64'd8,    64'h0000_0000_0000_00FF, "clr_already_clear");

    // get bit
    apply(0, 3'b010, 64'h8000_0000_0000_0001, 64'd63, 64'h1, "get_bit63");
    apply(0, 3'b010, 64'h8000_0000_0000_0001, 64'd1,  64'h0, "get_bit1");
    apply(0, 3'b010, 64'h8000_0000_0000_0001, 64'd0,  64'h1, "get_bit0");

    // shifts
    apply(0, 3'b100, 64'h8000_0000_0000_0010, 64'd4, 64'h0000_0000_0000_0100, "shl_4");
    apply(0, 3'b101, 64'h8000_0000_0000_0010, 64'd4, 64'h0800_0000_0000_0001, "shr_4");
    apply(0, 3'b110, 64'h8000_0000_0000_0010, 64'd4, 64'hF800_0000_0000_0001, "sra_4");
    apply(0, 3'b100, 64'h8000_0000_0000_0010, 64'd0, 64'h8000_0000_0000_0010, "shl_0");
    apply(0, 3'b101, 64'h8000_0000_0000_0010, 64'd0, 64'h8000_0000_0000_0010, "shr_0");
    apply(0, 3'b110, 64'h8000_0000_0000_0010, 64'd0, 64'h8000_0000_0000_0010, "sra_0");
    apply(0, 3'b110, 64'h4000_0000_0000_0000, 64'd62, 64'h0000_0000_0000_0001, "sra_positive");

    // rotate
    apply(0, 3'b111, 64'h8000_0000_0000_0001, 64'd1,  64'h0000_0000_0000_0003, "rol_1");
    apply(0, 3'b111, 64'h8000_0000_0000_0001, 64'd63, 64'hC000_0000_0000_0000, "rol_63");
    apply(0, 3'b111, 64'h8000_0000_0000_0001, 64'd0,  64'h8000_0000_0000_0001, "rol_0");
    apply(0, 3'b111, 64'h8000_0000_0000_0001, 64'd64, 64'h8000_0000_0000_0001, "rol_64_wraps_to_0");

    // latency / hold / mid-sequence reset
    apply(0, 3'b000, 64'h0000_0000_0000_00F0, 64'd3, 64'h0000_0000_0000_00F0, "seq_clr");
    apply(0, 3'b001, 64'h0000_0000_0000_00F0, 64'd3, 64'h0000_0000_0000_00F8, "seq_set");
    apply(0, 3'b001, 64'h0000_0000_0000_00F0, 64'd3, 64'h0000_0000_0000_00F8, "seq_hold");
    apply(1, 3'b001, 64'h0000_0000_0000_00F0, 64'd3, 64'h0,                   "seq_reset");
    apply(0, 3'b001, 64'h0000_0000_0000_00F0, 64'd3, 64'h0000_0000_0000_00F8, "seq_resume");
    apply(0, 3'b000, 64'h0000_0000_0000_00F0, 64'd3, 64'h0000_0000_0000_00F0, "seq_back_to_clr");

    stim_done = 1'b1;
    repeat (3) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
